// File: rtl/dac_spi_responder_pkg.sv
// Shared definitions for the AD5313R serial-interface responder:
// command encodings, frame geometry, address bit positions and FSM states.
package dac_spi_responder_pkg;

    localparam int FRAME_BITS = 24;

    // Bit counter values: a complete frame, and the saturation point that
    // marks any frame longer than FRAME_BITS.
    localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
    localparam logic [4:0] CNT_SAT  = 5'(FRAME_BITS + 1);

    localparam logic [3:0] CMD_NOP        = 4'h0;
    localparam logic [3:0] CMD_WR_INPUT   = 4'h1;
    localparam logic [3:0] CMD_UPDATE_DAC = 4'h2;
    localparam logic [3:0] CMD_WR_UPDATE  = 4'h3;
    localparam logic [3:0] CMD_POWER_DOWN = 4'h4;
    localparam logic [3:0] CMD_LDAC_MASK  = 4'h5;
    localparam logic [3:0] CMD_SW_RESET   = 4'h6;
    localparam logic [3:0] CMD_REF_SETUP  = 4'h7;
    localparam logic [3:0] CMD_READBACK   = 4'h9;

    // Positions inside the 4-bit address field.
    localparam int ADDR_DAC_A = 0;
    localparam int ADDR_DAC_B = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DECODE
    } state_e;

    typedef enum logic [1:0] {
        RB_NONE,
        RB_DAC_A,
        RB_DAC_B
    } rb_sel_e;

    // Readback serves the lowest addressed channel; no address means a zero word.
    function automatic rb_sel_e rb_select(input logic [3:0] addr);
        if (addr[ADDR_DAC_A]) begin
            return RB_DAC_A;
        end
        if (addr[ADDR_DAC_B]) begin
            return RB_DAC_B;
        end
        return RB_NONE;
    endfunction

endpackage

// File: rtl/dac_spi_responder_if.sv
// Serial bus between the DAC controller (master) and the responder (slave).
interface dac_spi_responder_if;
    logic sclk;
    logic sync_n;
    logic sdin;
    logic reset_n;
    logic sdo;

    modport master (
        output sclk,
        output sync_n,
        output sdin,
        output reset_n,
        input  sdo
    );

    modport slave (
        input  sclk,
        input  sync_n,
        input  sdin,
        input  reset_n,
        output sdo
    );
endinterface

// File: rtl/dac_spi_responder_spi_edge_sync.sv
// Multi-stage synchronizer for one asynchronous pin, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_edge_sync #(
    parameter int   C_SYNC_STAGES = 2,
    parameter logic C_RESET_VAL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    // One extra stage beyond the synchronizer holds the previous level.
    logic [C_SYNC_STAGES:0] r_chain;

    // Shift the pin through the chain; reset to the pin's idle level so no
    // spurious edge appears when reset releases.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments in clocked blocks so every flop samples
        // the pre-edge value of its neighbour; blocking here would collapse the chain.
        if (i_rst) begin
            r_chain <= {(C_SYNC_STAGES + 1){C_RESET_VAL}};
        end else begin
            r_chain <= {r_chain[C_SYNC_STAGES-1:0], i_pin};
        end
    end

    assign o_level = r_chain[C_SYNC_STAGES-1];
    assign o_rise  =  r_chain[C_SYNC_STAGES-1] & ~r_chain[C_SYNC_STAGES];
    assign o_fall  = ~r_chain[C_SYNC_STAGES-1] &  r_chain[C_SYNC_STAGES];

endmodule

// File: rtl/dac_spi_responder.sv
// AD5313R serial-interface responder: decodes 24-bit frames, keeps the
// two-channel input/DAC register file and serves readback on sdo.
module dac_spi_responder
    import dac_spi_responder_pkg::*;
#(
    parameter int C_SYNC_STAGES = 2,
    parameter int C_DAC_BITS    = 10
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    dac_spi_responder_if.slave    spi,
    output logic [C_DAC_BITS-1:0] dac_a_value,
    output logic [C_DAC_BITS-1:0] dac_b_value,
    output logic [C_DAC_BITS-1:0] input_a_value,
    output logic [C_DAC_BITS-1:0] input_b_value,
    output logic [3:0]            pd_mode,
    output logic [1:0]            ldac_mask,
    output logic                  ref_disable,
    output logic                  frame_valid,
    output logic [3:0]            frame_cmd,
    output logic                  frame_err
);

    // Synchronized pin levels and edges.
    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_sync_level, w_sync_rise, w_sync_fall;
    logic w_sdin_level, w_sdin_rise, w_sdin_fall;
    logic w_rstn_level, w_rstn_rise, w_rstn_fall;

    spi_edge_sync #(.C_SYNC_STAGES(C_SYNC_STAGES), .C_RESET_VAL(1'b1)) u_sync_sclk (
        .i_clk(sys_clk), .i_rst(sys_rst), .i_pin(spi.sclk),
        .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_edge_sync #(.C_SYNC_STAGES(C_SYNC_STAGES), .C_RESET_VAL(1'b1)) u_sync_sync_n (
        .i_clk(sys_clk), .i_rst(sys_rst), .i_pin(spi.sync_n),
        .o_level(w_sync_level), .o_rise(w_sync_rise), .o_fall(w_sync_fall)
    );
    spi_edge_sync #(.C_SYNC_STAGES(C_SYNC_STAGES), .C_RESET_VAL(1'b0)) u_sync_sdin (
        .i_clk(sys_clk), .i_rst(sys_rst), .i_pin(spi.sdin),
        .o_level(w_sdin_level), .o_rise(w_sdin_rise), .o_fall(w_sdin_fall)
    );
    spi_edge_sync #(.C_SYNC_STAGES(C_SYNC_STAGES), .C_RESET_VAL(1'b1)) u_sync_reset_n (
        .i_clk(sys_clk), .i_rst(sys_rst), .i_pin(spi.reset_n),
        .o_level(w_rstn_level), .o_rise(w_rstn_rise), .o_fall(w_rstn_fall)
    );

    // State and register file.
    state_e                  r_state;
    state_e                  w_state_next;
    logic [4:0]              r_bit_cnt;
    logic [FRAME_BITS-1:0]   r_shift;
    logic [FRAME_BITS-1:0]   r_sdo_shift;
    logic                    r_armed;
    logic                    r_rb_active;
    rb_sel_e                 r_rb_sel;
    logic [C_DAC_BITS-1:0]   r_dac_a, r_dac_b, r_input_a, r_input_b;
    logic [3:0]              r_pd_mode;
    logic [1:0]              r_ldac_mask;
    logic                    r_ref_disable;
    logic                    r_frame_valid;
    logic [3:0]              r_frame_cmd;
    logic                    r_frame_err;

    // Frame fields of the shifted-in word.
    logic [3:0]              w_cmd;
    logic [3:0]              w_addr;
    logic [15:0]             w_data;
    logic [C_DAC_BITS-1:0]   w_code;

    assign w_cmd  = r_shift[23:20];
    assign w_addr = r_shift[19:16];
    assign w_data = r_shift[15:0];
    assign w_code = w_data[15 -: C_DAC_BITS];

    // Device reset pin acts like a level reset of everything but the synchronizers.
    logic w_dev_rst;
    assign w_dev_rst = ~w_rstn_level;

    // sclk edges only count inside a frame while sync_n is still low.
    logic w_sclk_fall_in_frame, w_sclk_rise_in_frame;
    assign w_sclk_fall_in_frame = (r_state == ST_SHIFT) && w_sclk_fall && !w_sync_level;
    assign w_sclk_rise_in_frame = (r_state == ST_SHIFT) && w_sclk_rise && !w_sync_level;

    logic w_frame_start, w_frame_close, w_frame_full;
    assign w_frame_start = w_sync_fall && (r_state != ST_SHIFT);
    assign w_frame_close = w_sync_rise && (r_state == ST_SHIFT);
    assign w_frame_full  = (r_bit_cnt == CNT_FULL);

    // Readback word for the selected channel, left-justified in the data field.
    logic [C_DAC_BITS-1:0] w_rb_value;
    logic [15:0]           w_rb_field;
    logic [FRAME_BITS-1:0] w_rb_word;

    // Select the channel that an armed readback will return.
    always_comb begin
        w_rb_value = '0;
        case (r_rb_sel)
            RB_DAC_A: w_rb_value = r_dac_a;
            RB_DAC_B: w_rb_value = r_dac_b;
            default:  w_rb_value = '0;
        endcase
    end

    assign w_rb_field = 16'(w_rb_value) << (16 - C_DAC_BITS);
    assign w_rb_word  = {8'h00, w_rb_field};

    // Frame FSM next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns w_state_next and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_sync_fall) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_sync_rise) begin
                    w_state_next = w_frame_full ? ST_DECODE : ST_IDLE;
                end
            end
            ST_DECODE: begin
                w_state_next = w_sync_fall ? ST_SHIFT : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (w_dev_rst) begin
            w_state_next = ST_IDLE;
        end
    end

    // Frame FSM state register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Shifting, readback and command execution; resets clear everything.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || w_dev_rst) begin
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_sdo_shift   <= '0;
            r_armed       <= 1'b0;
            r_rb_active   <= 1'b0;
            r_rb_sel      <= RB_NONE;
            r_dac_a       <= '0;
            r_dac_b       <= '0;
            r_input_a     <= '0;
            r_input_b     <= '0;
            r_pd_mode     <= '0;
            r_ldac_mask   <= '0;
            r_ref_disable <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_cmd   <= '0;
            r_frame_err   <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_frame_err   <= w_frame_close && !w_frame_full;

            if (w_frame_start) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end else if (w_sclk_fall_in_frame) begin
                r_shift <= {r_shift[FRAME_BITS-2:0], w_sdin_level};
                if (r_bit_cnt != CNT_SAT) begin
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
            end

            if (w_frame_start && r_armed) begin
                r_sdo_shift <= w_rb_word;
                r_rb_active <= 1'b1;
            end else if (r_rb_active && w_sclk_rise_in_frame) begin
                r_sdo_shift <= {r_sdo_shift[FRAME_BITS-2:0], 1'b0};
            end

            // The frame that carried the readback ends the armed period.
            if (w_frame_close) begin
                r_rb_active <= 1'b0;
                r_sdo_shift <= '0;
                if (r_rb_active) begin
                    r_armed <= 1'b0;
                end
            end

            if (r_state == ST_DECODE) begin
                r_frame_valid <= 1'b1;
                r_frame_cmd   <= w_cmd;
                case (w_cmd)
                    CMD_WR_INPUT: begin
                        if (w_addr[ADDR_DAC_A]) r_input_a <= w_code;
                        if (w_addr[ADDR_DAC_B]) r_input_b <= w_code;
                    end
                    CMD_UPDATE_DAC: begin
                        if (w_addr[ADDR_DAC_A]) r_dac_a <= r_input_a;
                        if (w_addr[ADDR_DAC_B]) r_dac_b <= r_input_b;
                    end
                    CMD_WR_UPDATE: begin
                        if (w_addr[ADDR_DAC_A]) begin
                            r_input_a <= w_code;
                            r_dac_a   <= w_code;
                        end
                        if (w_addr[ADDR_DAC_B]) begin
                            r_input_b <= w_code;
                            r_dac_b   <= w_code;
                        end
                    end
                    CMD_POWER_DOWN: r_pd_mode     <= w_data[3:0];
                    CMD_LDAC_MASK:  r_ldac_mask   <= w_data[1:0];
                    CMD_REF_SETUP:  r_ref_disable <= w_data[0];
                    CMD_SW_RESET: begin
                        r_dac_a       <= '0;
                        r_dac_b       <= '0;
                        r_input_a     <= '0;
                        r_input_b     <= '0;
                        r_pd_mode     <= '0;
                        r_ldac_mask   <= '0;
                        r_ref_disable <= 1'b0;
                        r_armed       <= 1'b0;
                        r_rb_active   <= 1'b0;
                        r_rb_sel      <= RB_NONE;
                        r_sdo_shift   <= '0;
                    end
                    CMD_READBACK: begin
                        r_armed  <= 1'b1;
                        r_rb_sel <= rb_select(w_addr);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Edge pulses and data bits that this responder has no use for.
    logic w_unused;
    assign w_unused = &{w_sclk_level, w_sdin_rise, w_sdin_fall,
                        w_rstn_rise, w_rstn_fall, w_data[5:4]};

    assign spi.sdo       = r_rb_active & r_sdo_shift[FRAME_BITS-1];
    assign dac_a_value   = r_dac_a;
    assign dac_b_value   = r_dac_b;
    assign input_a_value = r_input_a;
    assign input_b_value = r_input_b;
    assign pd_mode       = r_pd_mode;
    assign ldac_mask     = r_ldac_mask;
    assign ref_disable   = r_ref_disable;
    assign frame_valid   = r_frame_valid;
    assign frame_cmd     = r_frame_cmd;
    assign frame_err     = r_frame_err;

endmodule

// File: tb/tb_dac_spi_responder.sv
// Directed bench for dac_spi_responder: drives SPI frames through the bus
// interface and compares registers, pulses and readback data against
// hand-computed values.
module tb_dac_spi_responder;

    localparam int HALF = 8;   // sys_clk cycles per sclk half period

    logic       sys_clk;
    logic       sys_rst;
    logic [9:0] dac_a_value, dac_b_value, input_a_value, input_b_value;
    logic [3:0] pd_mode;
    logic [1:0] ldac_mask;
    logic       ref_disable;
    logic       frame_valid;
    logic [3:0] frame_cmd;
    logic       frame_err;

    dac_spi_responder_if spi_if ();

    dac_spi_responder #(.C_SYNC_STAGES(2), .C_DAC_BITS(10)) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .spi           (spi_if),
        .dac_a_value   (dac_a_value),
        .dac_b_value   (dac_b_value),
        .input_a_value (input_a_value),
        .input_b_value (input_b_value),
        .pd_mode       (pd_mode),
        .ldac_mask     (ldac_mask),
        .ref_disable   (ref_disable),
        .frame_valid   (frame_valid),
        .frame_cmd     (frame_cmd),
        .frame_err     (frame_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Results of the most recent frame.
    logic [23:0] rx_word;
    logic        got_valid, got_err;
    int          lat_valid, lat_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Send nbits of value MSB first, capturing sdo before each sclk fall.
    // abort_at >= 0 pulses reset_n low just before that bit is driven.
    task automatic send_frame(input logic [31:0] value, input int nbits, input int abort_at);
        rx_word   = '0;
        got_valid = 1'b0;
        got_err   = 1'b0;
        lat_valid = 0;
        lat_err   = 0;
        spi_if.sync_n = 1'b0;
        wait_clks(HALF);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (i == abort_at) begin
                spi_if.reset_n = 1'b0;
                wait_clks(6);
                spi_if.reset_n = 1'b1;
                wait_clks(6);
            end
            spi_if.sdin = value[i];
            wait_clks(HALF);
            rx_word = {rx_word[22:0], spi_if.sdo};
            spi_if.sclk = 1'b0;
            wait_clks(HALF);
            spi_if.sclk = 1'b1;
        end
        wait_clks(HALF);
        spi_if.sync_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            wait_clks(1);
            if (frame_valid && !got_valid) begin
                got_valid = 1'b1;
                lat_valid = k;
            end
            if (frame_err && !got_err) begin
                got_err = 1'b1;
                lat_err = k;
            end
        end
        spi_if.sdin = 1'b0;
    endtask

    initial begin
        sys_rst        = 1'b1;
        spi_if.sclk    = 1'b1;
        spi_if.sync_n  = 1'b1;
        spi_if.sdin    = 1'b0;
        spi_if.reset_n = 1'b1;
        wait_clks(5);
        sys_rst = 1'b0;
        wait_clks(2);

        // Reset state
        check("rst_dac_a",   32'(dac_a_value),   32'h0);
        check("rst_dac_b",   32'(dac_b_value),   32'h0);
        check("rst_input_a", 32'(input_a_value), 32'h0);
        check("rst_input_b", 32'(input_b_value), 32'h0);
        check("rst_misc",    32'({pd_mode, ldac_mask, ref_disable, frame_cmd}), 32'h0);
        check("rst_pulses",  32'({frame_valid, frame_err}), 32'h0);
        check("rst_sdo",     32'(spi_if.sdo), 32'h0);

        // Write input + DAC on channel A
        send_frame(32'h0031_FFC0, 24, -1);
        check("wu_valid",     32'(got_valid), 32'h1);
        check("wu_valid_lat", 32'(lat_valid), 32'd4);
        check("wu_no_err",    32'(got_err),   32'h0);
        check("wu_cmd",       32'(frame_cmd), 32'h3);
        check("wu_dac_a",     32'(dac_a_value),   32'h3FF);
        check("wu_input_a",   32'(input_a_value), 32'h3FF);
        check("wu_dac_b",     32'(dac_b_value),   32'h0);
        check("wu_input_b",   32'(input_b_value), 32'h0);

        // Input register on B, then copy to DAC B
        send_frame(32'h0012_8000, 24, -1);
        check("wi_input_b", 32'(input_b_value), 32'h200);
        check("wi_dac_b",   32'(dac_b_value),   32'h0);
        send_frame(32'h0022_0000, 24, -1);
        check("ud_dac_b",   32'(dac_b_value),   32'h200);
        check("ud_cmd",     32'(frame_cmd),     32'h2);
        check("ud_dac_a",   32'(dac_a_value),   32'h3FF);

        // Readback of DAC A = 0x155
        send_frame(32'h0031_5540, 24, -1);
        check("rb_setup_dac_a", 32'(dac_a_value), 32'h155);
        send_frame(32'h0093_0000, 24, -1);
        check("rb_arm_cmd", 32'(frame_cmd), 32'h9);
        check("rb_idle_sdo", 32'(spi_if.sdo), 32'h0);
        send_frame(32'h0000_0000, 24, -1);
        check("rb_word", 32'(rx_word), 32'h00_5540);
        check("rb_after_sdo", 32'(spi_if.sdo), 32'h0);
        send_frame(32'h0000_0000, 24, -1);
        check("rb_disarmed_word", 32'(rx_word), 32'h0);

        // Short and long frames are discarded
        send_frame(32'h0031_0000, 23, -1);
        check("short_err",     32'(got_err),   32'h1);
        check("short_err_lat", 32'(lat_err),   32'd3);
        check("short_valid",   32'(got_valid), 32'h0);
        send_frame(32'h0031_0000, 25, -1);
        check("long_err",      32'(got_err),   32'h1);
        check("long_valid",    32'(got_valid), 32'h0);
        check("len_dac_a",     32'(dac_a_value),   32'h155);
        check("len_input_b",   32'(input_b_value), 32'h200);

        // Device reset mid-frame
        send_frame(32'h0031_AA80, 24, -1);
        check("dr_setup_dac_a", 32'(dac_a_value), 32'h2AA);
        send_frame(32'h0031_0000, 24, 12);
        check("dr_no_err",   32'(got_err),   32'h0);
        check("dr_no_valid", 32'(got_valid), 32'h0);
        check("dr_dacs",     32'({dac_a_value, dac_b_value}),     32'h0);
        check("dr_inputs",   32'({input_a_value, input_b_value}), 32'h0);
        send_frame(32'h0033_0400, 24, -1);
        check("dr_next_valid", 32'(got_valid),   32'h1);
        check("dr_next_dac_a", 32'(dac_a_value), 32'h010);
        check("dr_next_dac_b", 32'(dac_b_value), 32'h010);

        // Power-down, LDAC mask, reference, then software reset
        send_frame(32'h0040_000E, 24, -1);
        check("pd_mode", 32'(pd_mode), 32'hE);
        send_frame(32'h0070_0001, 24, -1);
        check("ref_disable", 32'(ref_disable), 32'h1);
        send_frame(32'h0050_0003, 24, -1);
        check("ldac_mask", 32'(ldac_mask), 32'h3);
        check("ldac_cmd",  32'(frame_cmd), 32'h5);
        send_frame(32'h0060_0000, 24, -1);
        check("sw_pd_mode",     32'(pd_mode),     32'h0);
        check("sw_ref_disable", 32'(ref_disable), 32'h0);
        check("sw_ldac_mask",   32'(ldac_mask),   32'h0);
        check("sw_dac_a",       32'(dac_a_value), 32'h0);
        check("sw_dac_b",       32'(dac_b_value), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dac_spi_responder.md
# dac_spi_responder

Synthesizable responder for the AD5313R serial interface driven by the DAC controller. It decodes 24-bit frames on sync_n/sclk/sdin, maintains the two-channel DAC register file, and serves readback data on sdo. It sits opposite the DAC controller in loopback builds and simulation benches, so the controller can be checked without silicon.

## Interface
- C_SYNC_STAGES, 2: synchronizer depth for sclk, sync_n, sdin and reset_n.
- C_DAC_BITS, 10: DAC code width, left-justified in the 16-bit data field (DB15..DB6).

- sys_clk  in  1  system clock; all logic is on this clock. One clock; reset is synchronous and active-high.
- sys_rst  in  1  synchronous active-high reset.
- sclk  in  1  SPI clock from the controller. Period must be at least 4 sys_clk.
- sync_n  in  1  frame select, active low.
- sdin  in  1  serial data, MSB first.
- reset_n  in  1  device hardware reset, active low.
- sdo  out  1  readback serial data.
- dac_a_value, dac_b_value  out  C_DAC_BITS  DAC registers.
- input_a_value, input_b_value  out  C_DAC_BITS  input registers.
- pd_mode  out  4  power-down bits: [1:0] DAC A, [3:2] DAC B.
- ldac_mask  out  2  stored LDAC mask.
- ref_disable  out  1  internal reference disabled.
- frame_valid  out  1  one-cycle pulse when a frame is accepted.
- frame_cmd  out  4  command of the last accepted frame.
- frame_err  out  1  one-cycle pulse when a frame is discarded.

## Operation
- Inputs pass through C_SYNC_STAGES flops. Edges are detected on the synchronized copies.
- States:
  - IDLE: leave on sync_n fall → SHIFT.
  - SHIFT: shift sdin in on each sclk falling edge; 5-bit bit counter saturates at 25.
  - On sync_n rise: bit count 24 → DECODE; any other count → frame_err, back to IDLE.
  - DECODE: 1 cycle, then IDLE.
- Frame layout: [23:20] cmd, [19:16] addr (bit0 = DAC A, bit1 = DAC B), [15:0] data, code = data[15:6].
- Commands (apply to every addressed channel):
  - 0000: no-op.
  - 0001: write input register.
  - 0010: copy input register to DAC register.
  - 0011: write both input and DAC registers.
  - 0100: pd_mode ← data[3:0].
  - 0101: ldac_mask ← data[1:0].
  - 0110: software reset.
  - 0111: ref_disable ← data[0].
  - 1001: arm readback of the lowest set addr bit. With no addr bit set, the readback word is 0.
  - 1000 and 1010–1111: accepted as no-op.
- Readback:
  - On the next sync_n fall, load sdo_shift = {8'h00, selected DAC register, 6'b0}.
  - sdo drives the MSB immediately, then shifts on each sclk rising edge; zeros after 24 bits.
  - The armed flag clears at the end of that frame, accepted or not.
  - When not armed, sdo = 0.
- Software reset, reset_n low, or sys_rst clear all registers to 0 and disarm readback.
- reset_n low or sys_rst also abort any frame in progress without asserting frame_err.
- sys_rst is synchronous and takes priority over every other event.

## Timing
- Every output resets to 0.
- Pin sync_n rise → register outputs, frame_valid and frame_cmd update C_SYNC_STAGES+2 cycles later.
- frame_err asserts C_SYNC_STAGES+1 cycles after the sync_n rise.
- sdo changes C_SYNC_STAGES+1 cycles after the pin sclk rising edge.
- sync_n fall while in DECODE: the new frame starts normally; the decode completes first.
- sclk edges while sync_n is high are ignored.

## Structure
- Shared package holds:
  - command encodings CMD_NOP … CMD_READBACK,
  - FRAME_BITS = 24,
  - the state enum,
  - the address bit positions.
- One sub-module, spi_edge_sync: a C_SYNC_STAGES synchronizer with rise/fall pulse outputs, instantiated per input pin.

## Test plan
- Frame 0x31_FFC0 (cmd 0011, DAC A) → dac_a_value = input_a_value = 0x3FF, frame_valid with frame_cmd = 3, DAC B unchanged.
- Frame 0x12_8000, then 0x22_0000 → input_b_value = 0x200 after the first frame, dac_b_value = 0x200 only after the second.
- Frame 0x93_0000, then a 24-bit no-op frame with dac_a_value = 0x155 → sdo stream 0x00_5540 MSB first; the following frame returns all zeros.
- 23-bit frame, then a 25-bit frame → two frame_err pulses, registers unchanged, no frame_valid.
- reset_n pulsed low mid-frame after writing 0x2AA → all registers 0, no frame_err, next valid frame accepted.
- Frame 0x40_000E, then 0x70_0001 → pd_mode = 4'hE, ref_disable = 1; frame 0x60_0000 → both return to 0.
